// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Sends one byte (start, 8 data LSB first, odd parity, stop) and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 600,
    parameter int START_SETUP_CYCLES = 10,
    parameter int RTS_TIMEOUT_CYCLES = 75000,
    parameter int BIT_TIMEOUT_CYCLES = 10000,
    parameter int FILTER_LEN         = 4
) (
    input  logic       iBusClk,
    input  logic       iRstN,
    input  logic       iStart,
    input  logic [7:0] iData,
    inout  wire        ps2clk,
    inout  wire        ps2data,
    output logic       oBusy,
    output logic       oDone,
    output logic       oAckOk,
    output logic       oErr
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = 17;

    typedef enum logic [2:0] {IDLE, INHIBIT, START, WAIT_FIRST, SEND, WAIT_IDLE, ERROR} state_t;

    state_t         state_q;
    logic [1:0]     clk_sync_q, dat_sync_q;
    logic [FW-1:0]  clk_cnt_q, dat_cnt_q, clk_cnt_d, dat_cnt_d;
    logic           clk_f_q, dat_f_q, clk_f_d, dat_f_d, clk_f_prev_q;
    logic [8:0]     sh_q;
    logic [3:0]     k_q;
    logic [TW-1:0]  timer_q, timer_inc;
    logic           clk_oe_q, data_oe_q, busy_q, done_q, ack_q, err_q;
    logic           fall;

    assign ps2clk  = clk_oe_q  ? 1'b0 : 1'bz;
    assign ps2data = data_oe_q ? 1'b0 : 1'bz;
    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oAckOk  = ack_q;
    assign oErr    = err_q;

    // A filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        clk_cnt_d = (clk_sync_q[1] == clk_f_q) ? '0 : clk_cnt_q + 1'b1;
        dat_cnt_d = (dat_sync_q[1] == dat_f_q) ? '0 : dat_cnt_q + 1'b1;
        clk_f_d   = (clk_cnt_d == FW'(FILTER_LEN)) ? ~clk_f_q : clk_f_q;
        dat_f_d   = (dat_cnt_d == FW'(FILTER_LEN)) ? ~dat_f_q : dat_f_q;
        if (clk_cnt_d == FW'(FILTER_LEN)) clk_cnt_d = '0;
        if (dat_cnt_d == FW'(FILTER_LEN)) dat_cnt_d = '0;
    end

    assign fall      = clk_f_prev_q & ~clk_f_q;
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            clk_sync_q   <= 2'b11;
            dat_sync_q   <= 2'b11;
            clk_cnt_q    <= '0;
            dat_cnt_q    <= '0;
            clk_f_q      <= 1'b1;
            dat_f_q      <= 1'b1;
            clk_f_prev_q <= 1'b1;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2clk};
            dat_sync_q   <= {dat_sync_q[0], ps2data};
            clk_cnt_q    <= clk_cnt_d;
            dat_cnt_q    <= dat_cnt_d;
            clk_f_q      <= clk_f_d;
            dat_f_q      <= dat_f_d;
            clk_f_prev_q <= clk_f_q;
        end
    end

    always_ff @(posedge iBusClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            k_q       <= '0;
            timer_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (iStart) begin
                        sh_q     <= {~^iData, iData};
                        busy_q   <= 1'b1;
                        ack_q    <= 1'b0;
                        clk_oe_q <= 1'b1;
                        state_q  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (timer_q >= TW'(INHIBIT_CYCLES - 1)) begin
                        data_oe_q <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= START;
                    end else timer_q <= timer_inc;
                end
                START: begin
                    if (timer_q >= TW'(START_SETUP_CYCLES - 1)) begin
                        clk_oe_q <= 1'b0;
                        timer_q  <= '0;
                        state_q  <= WAIT_FIRST;
                    end else timer_q <= timer_inc;
                end
                WAIT_FIRST: begin
                    if (fall) begin
                        data_oe_q <= ~sh_q[0];
                        sh_q      <= {1'b1, sh_q[8:1]};
                        k_q       <= 4'd1;
                        timer_q   <= '0;
                        state_q   <= SEND;
                    end else if (timer_q >= TW'(RTS_TIMEOUT_CYCLES)) begin
                        data_oe_q <= 1'b0;
                        state_q   <= ERROR;
                    end else timer_q <= timer_inc;
                end
                SEND: begin
                    // Ones shift in behind parity, so the ninth edge releases data for the stop bit.
                    if (fall) begin
                        timer_q <= '0;
                        k_q     <= k_q + 1'b1;
                        if (k_q == 4'd10) begin
                            ack_q     <= ~dat_f_q;
                            data_oe_q <= 1'b0;
                            state_q   <= WAIT_IDLE;
                        end else begin
                            data_oe_q <= ~sh_q[0];
                            sh_q      <= {1'b1, sh_q[8:1]};
                        end
                    end else if (timer_q >= TW'(BIT_TIMEOUT_CYCLES)) begin
                        data_oe_q <= 1'b0;
                        state_q   <= ERROR;
                    end else timer_q <= timer_inc;
                end
                WAIT_IDLE: begin
                    if (clk_f_q && dat_f_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (timer_q >= TW'(BIT_TIMEOUT_CYCLES)) state_q <= ERROR;
                    else timer_q <= timer_inc;
                end
                ERROR: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    err_q     <= 1'b1;
                    ack_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model plus frame/ACK/timeout checks for ps2_host_tx.
module tb_ps2_host_tx;
    localparam int INH = 600;
    localparam int RTS = 7500;
    localparam int BIT = 10000;
    localparam int FL  = 4;

    logic       clk = 0, rst_n = 0, start = 0;
    logic [7:0] data = 0;
    logic       dev_clk = 0, dev_dat = 0;
    logic       busy, done, ackok, err;
    wire        ps2clk, ps2data;

    pullup (ps2clk);
    pullup (ps2data);
    assign ps2clk  = dev_clk ? 1'b0 : 1'bz;
    assign ps2data = dev_dat ? 1'b0 : 1'bz;

    ps2_host_tx #(.RTS_TIMEOUT_CYCLES(RTS), .BIT_TIMEOUT_CYCLES(BIT), .FILTER_LEN(FL)) dut (
        .iBusClk(clk), .iRstN(rst_n), .iStart(start), .iData(data),
        .ps2clk(ps2clk), .ps2data(ps2data),
        .oBusy(busy), .oDone(done), .oAckOk(ackok), .oErr(err)
    );

    always #5 clk = ~clk;

    int   cyc, checks, errors, done_cnt, err_cnt, err_cyc, edge_cyc;
    logic done_ack, done_busy;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_ack  = ackok;
            done_busy = busy;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame as the device should see it: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic pulse_start(input logic [7:0] d);
        @(negedge clk);
        start = 1;
        data  = d;
        @(negedge clk);
        start = 0;
    endtask

    task automatic dev_frame(input int h, input int n, input bit ack, output logic [9:0] bits, output int low_cyc);
        int w = 0;
        bits    = '0;
        low_cyc = 0;
        while (ps2clk !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        while (ps2clk === 1'b0 && low_cyc < 5000) begin @(negedge clk); low_cyc++; end
        check("rts_start_bit", {31'd0, ps2data}, 0);
        repeat (h) @(negedge clk);
        for (int e = 1; e <= n; e++) begin
            dev_clk  = 1;
            edge_cyc = cyc;
            repeat (h) @(negedge clk);
            dev_clk = 0;
            repeat (h / 2) @(negedge clk);
            if (e <= 10) bits[e-1] = ps2data;
            if (e == 10 && ack) dev_dat = 1;
            repeat (h - h / 2) @(negedge clk);
        end
        dev_dat = 0;
    endtask

    task automatic wait_end(input int d0, input int e0);
        int w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < 3000) begin @(negedge clk); w++; end
        check("end_within_bound", {31'd0, w < 3000}, 1);
    endtask

    typedef struct {
        logic [7:0] d;
        bit         ack;
        int         h;
        logic [9:0] exp_bits;
        logic       exp_ack;
    } vec_t;

    vec_t       vt[6];
    logic [9:0] bits;
    int         lc, d0, e0, w, c0;

    initial begin
        vt[0] = '{8'hF4, 1'b1, 200, 10'b1_0_11110100, 1'b1};
        vt[1] = '{8'hFF, 1'b0, 200, 10'b1_1_11111111, 1'b0};
        for (int i = 2; i < 6; i++) begin
            vt[i].d        = 8'($urandom);
            vt[i].ack      = 1'($urandom % 2);
            vt[i].h        = int'($urandom_range(20, 60));
            vt[i].exp_bits = frame_of(vt[i].d);
            vt[i].exp_ack  = vt[i].ack;
        end

        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, busy, done, ackok, err}, 0);
        check("reset_lines", {30'd0, ps2clk, ps2data}, 2'b11);
        rst_n = 1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            pulse_start(vt[i].d);
            check("busy_on_start", {31'd0, busy}, 1);
            dev_frame(vt[i].h, 11, vt[i].ack, bits, lc);
            wait_end(d0, e0);
            check("frame_bits", {22'd0, bits}, {22'd0, vt[i].exp_bits});
            check("inhibit_len", {31'd0, lc >= INH}, 1);
            check("done_count", done_cnt, d0 + 1);
            check("no_err", err_cnt, e0);
            check("ack_at_done", {31'd0, done_ack}, {31'd0, vt[i].exp_ack});
            check("busy_falls_with_done", {31'd0, done_busy}, 0);
            repeat (20) @(negedge clk);
            check("ack_hold", {31'd0, ackok}, {31'd0, vt[i].exp_ack});
            check("idle_lines", {30'd0, ps2clk, ps2data}, 2'b11);
        end

        // device never clocks after the request
        e0 = err_cnt;
        d0 = done_cnt;
        pulse_start(8'hF4);
        w = 0;
        while (ps2clk !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        c0 = cyc;
        w = 0;
        while (err_cnt == e0 && w < RTS + 100) begin @(negedge clk); w++; end
        check("rts_err_seen", err_cnt, e0 + 1);
        check("rts_timeout_window", {31'd0, (err_cyc - c0 >= RTS) && (err_cyc - c0 <= RTS + FL + 3)}, 1);
        check("rts_lines", {30'd0, ps2clk, ps2data}, 2'b11);
        check("rts_busy", {30'd0, busy, ackok}, 0);
        check("rts_no_done", done_cnt, d0);

        // device stops after 4 edges, then a normal frame follows
        e0 = err_cnt;
        pulse_start(8'hF4);
        dev_frame(40, 4, 1'b0, bits, lc);
        c0 = edge_cyc;
        w = 0;
        while (err_cnt == e0 && w < BIT + 200) begin @(negedge clk); w++; end
        check("bit_err_seen", err_cnt, e0 + 1);
        check("bit_timeout_window", {31'd0, (err_cyc - c0 >= BIT) && (err_cyc - c0 <= BIT + FL + 12)}, 1);
        check("bit_lines", {30'd0, ps2clk, ps2data}, 2'b11);
        check("bit_busy", {31'd0, busy}, 0);
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(8'hF4);
        dev_frame(40, 11, 1'b1, bits, lc);
        wait_end(d0, e0);
        check("after_err_bits", {22'd0, bits}, {22'd0, 10'b1_0_11110100});
        check("after_err_done", {31'd0, done_ack}, 1);

        // second iStart mid-frame is ignored
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(8'hA5);
        fork
            dev_frame(40, 11, 1'b1, bits, lc);
            begin
                repeat (1200) @(negedge clk);
                start = 1;
                data  = 8'h00;
                @(negedge clk);
                start = 0;
            end
        join
        wait_end(d0, e0);
        check("midframe_bits", {22'd0, bits}, {22'd0, frame_of(8'hA5)});
        check("midframe_done", done_cnt, d0 + 1);
        repeat (50) @(negedge clk);
        check("midframe_no_restart", {31'd0, busy}, 0);

        // reset in the middle of the frame
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(8'h00);
        dev_frame(40, 6, 1'b0, bits, lc);
        check("host_drives_bit", {31'd0, ps2data}, 0);
        #2 rst_n = 0;
        #1 check("reset_releases_lines", {30'd0, ps2clk, ps2data}, 2'b11);
        repeat (20) @(negedge clk);
        check("reset_no_pulses", done_cnt + err_cnt, d0 + e0);
        rst_n = 1;
        repeat (30) @(negedge clk);
        check("post_reset_outputs", {28'd0, busy, done, ackok, err}, 0);
        check("post_reset_lines", {30'd0, ps2clk, ps2data}, 2'b11);
        check("post_reset_no_pulses", done_cnt + err_cnt, d0 + e0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end
endmodule
